// File: rtl/iir_df2_filter.sv
// Direct Form II biquad IIR filter: one sample per cycle, two-cycle latency.
// Floor-truncated Q1.FRAC products, NB+2-bit sums, saturation on w and y.
module iir_df2_filter #(
  parameter int unsigned NB   = 12,
  parameter int unsigned FRAC = 11
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic signed [NB-1:0] DIN,
  input  logic                 VIN,
  input  logic signed [NB-1:0] A1,
  input  logic signed [NB-1:0] A2,
  input  logic signed [NB-1:0] B0,
  input  logic signed [NB-1:0] B1,
  input  logic signed [NB-1:0] B2,
  output logic signed [NB-1:0] DOUT,
  output logic                 VOUT
);

  localparam int unsigned AW = NB + 2;
  localparam int unsigned PW = 2 * NB;

  localparam logic signed [AW-1:0] SatMax = {{(AW-NB+1){1'b0}}, {(NB-1){1'b1}}};
  localparam logic signed [AW-1:0] SatMin = {{(AW-NB+1){1'b1}}, {(NB-1){1'b0}}};

  logic signed [NB-1:0] x_q;
  logic                 v_q;
  logic signed [NB-1:0] w1_q, w2_q;
  logic signed [NB-1:0] dout_q;
  logic                 vout_q;

  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] w_sum, y_sum;
  logic signed [NB-1:0] w, y;

  // Full-width signed product, floor shift, keep AW bits.
  function automatic logic signed [AW-1:0] trunc_q(input logic signed [NB-1:0] c,
                                                   input logic signed [NB-1:0] s);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] ps;
    p  = $signed({{NB{c[NB-1]}}, c}) * $signed({{NB{s[NB-1]}}, s});
    ps = p >>> FRAC;
    return ps[AW-1:0];
  endfunction

  function automatic logic signed [NB-1:0] sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] c;
    if (v > SatMax) begin
      c = SatMax;
    end else if (v < SatMin) begin
      c = SatMin;
    end else begin
      c = v;
    end
    return c[NB-1:0];
  endfunction

  always_comb begin
    x_ext = {{(AW-NB){x_q[NB-1]}}, x_q};
    w_sum = x_ext - trunc_q(A1, w1_q) - trunc_q(A2, w2_q);
    w     = sat(w_sum);
    y_sum = trunc_q(B0, w) + trunc_q(B1, w1_q) + trunc_q(B2, w2_q);
    y     = sat(y_sum);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      x_q <= '0;
      v_q <= 1'b0;
    end else begin
      x_q <= DIN;
      v_q <= VIN;
    end
  end

  // State advances only on valid samples so VIN gaps leave history intact.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      w1_q   <= '0;
      w2_q   <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
    end else begin
      vout_q <= v_q;
      if (v_q) begin
        dout_q <= y;
        w2_q   <= w1_q;
        w1_q   <= w;
      end
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;

endmodule

// File: tb/tb_iir_df2_filter.sv
// Directed and model-checked bench for iir_df2_filter.
module tb_iir_df2_filter;

  localparam int NB   = 12;
  localparam int FRAC = 11;

  logic                 clk;
  logic                 rst_n;
  logic signed [NB-1:0] din;
  logic                 vin;
  logic signed [NB-1:0] a1, a2, b0, b1, b2;
  logic signed [NB-1:0] dout;
  logic                 vout;

  int n_checks = 0;
  int n_pass   = 0;

  iir_df2_filter #(
    .NB   (NB),
    .FRAC (FRAC)
  ) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .DIN   (din),
    .VIN   (vin),
    .A1    (a1),
    .A2    (a2),
    .B0    (b0),
    .B1    (b1),
    .B2    (b2),
    .DOUT  (dout),
    .VOUT  (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive at the falling edge, return at the next falling edge.
  task automatic cycle(input int d, input logic v);
    din = d[NB-1:0];
    vin = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    din   = '0;
    vin   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_coef(input int c_b0, input int c_b1, input int c_b2,
                          input int c_a1, input int c_a2);
    b0 = c_b0[NB-1:0];
    b1 = c_b1[NB-1:0];
    b2 = c_b2[NB-1:0];
    a1 = c_a1[NB-1:0];
    a2 = c_a2[NB-1:0];
  endtask

  // Golden model: floor products, clamp w and y.
  int m_w1, m_w2;

  function automatic int m_sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int m_tr(input int c, input int s);
    int p;
    int q;
    p = c * s;
    q = p / 2048;
    if ((p % 2048) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  function automatic int m_step(input int c_b0, input int c_b1, input int c_b2,
                                input int c_a1, input int c_a2, input int x);
    int w;
    int y;
    w    = m_sat(x - m_tr(c_a1, m_w1) - m_tr(c_a2, m_w2));
    y    = m_sat(m_tr(c_b0, w) + m_tr(c_b1, m_w1) + m_tr(c_b2, m_w2));
    m_w2 = m_w1;
    m_w1 = w;
    return y;
  endfunction

  initial begin
    int imp[4];
    int imp_exp[4];
    int c_b0, c_b1, c_b2, c_a1, c_a2;
    int prev_y, last_y, x, y;
    logic prev_v;

    rst_n = 1'b0;
    din   = '0;
    vin   = 1'b0;
    set_coef(1024, 0, 0, 0, 0);
    @(negedge clk);
    check_eq("reset_dout", dout, 0);
    check_eq("reset_vout", vout, 0);
    rst_n = 1'b1;

    // Pass-through gain of one half.
    cycle(1000, 1'b1);
    cycle(0, 1'b0);
    check_eq("pass_vout", vout, 1);
    check_eq("pass_pos", dout, 500);
    cycle(0, 1'b0);
    check_eq("pass_vout_pulse", vout, 0);
    check_eq("pass_hold", dout, 500);
    cycle(-1000, 1'b1);
    cycle(0, 1'b0);
    check_eq("pass_neg", dout, -500);

    // Asynchronous reset in the middle of a cycle.
    cycle(1000, 1'b1);
    cycle(0, 1'b0);
    check_eq("pre_reset_dout", dout, 500);
    check_eq("pre_reset_vout", vout, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_dout", dout, 0);
    check_eq("async_rst_vout", vout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse response, back-to-back.
    imp     = '{1000, 0, 0, 0};
    imp_exp = '{500, 250, 125, 62};
    set_coef(1024, 0, 0, -1024, 0);
    do_reset();
    cycle(imp[0], 1'b1);
    for (int i = 1; i < 4; i++) begin
      cycle(imp[i], 1'b1);
      check_eq($sformatf("imp_vout%0d", i - 1), vout, 1);
      check_eq($sformatf("imp_dout%0d", i - 1), dout, imp_exp[i - 1]);
    end
    cycle(0, 1'b0);
    check_eq("imp_dout3", dout, imp_exp[3]);

    // Same impulse with three idle cycles between samples.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(imp[i], 1'b1);
      cycle(0, 1'b0);
      check_eq($sformatf("gap_vout%0d", i), vout, 1);
      check_eq($sformatf("gap_dout%0d", i), dout, imp_exp[i]);
      for (int g = 0; g < 2; g++) begin
        cycle(0, 1'b0);
        check_eq($sformatf("gap_idle_vout%0d_%0d", i, g), vout, 0);
        check_eq($sformatf("gap_idle_dout%0d_%0d", i, g), dout, imp_exp[i]);
      end
    end

    // Positive saturation of w.
    set_coef(1024, 0, 0, -2047, 0);
    do_reset();
    cycle(2047, 1'b1);
    cycle(2047, 1'b1);
    check_eq("satp_dout0", dout, 1023);
    cycle(0, 1'b0);
    check_eq("satp_dout1", dout, 1023);

    // Negative mirror.
    do_reset();
    cycle(-2048, 1'b1);
    cycle(-2048, 1'b1);
    check_eq("satn_dout0", dout, -1024);
    cycle(0, 1'b0);
    check_eq("satn_dout1", dout, -1024);

    // Random biquad against the golden model.
    c_b0 = $urandom_range(0, 2047) - 1024;
    c_b1 = $urandom_range(0, 2047) - 1024;
    c_b2 = $urandom_range(0, 2047) - 1024;
    c_a1 = $urandom_range(0, 2047) - 1024;
    c_a2 = $urandom_range(0, 1023) - 512;
    set_coef(c_b0, c_b1, c_b2, c_a1, c_a2);
    do_reset();
    m_w1   = 0;
    m_w2   = 0;
    prev_v = 1'b0;
    prev_y = 0;
    last_y = 0;
    for (int i = 0; i < 1000; ) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, 4095) - 2048;
      if (v) begin
        y = m_step(c_b0, c_b1, c_b2, c_a1, c_a2, x);
        i++;
      end
      cycle(x, v);
      check_eq("rand_vout", vout, int'(prev_v));
      if (prev_v) last_y = prev_y;
      check_eq("rand_dout", dout, last_y);
      prev_v = v;
      if (v) prev_y = y;
    end
    cycle(0, 1'b0);
    check_eq("rand_vout_last", vout, int'(prev_v));
    check_eq("rand_dout_last", dout, prev_y);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
